// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, DMA) data-memory arbiter: IDLE -> ACCESS -> RESP, ack 3 edges after grant.
// Optional macro DMEM_ARB_RR_EN selects round-robin on ties; default is fixed CPU priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic [DATA_W-1:0] dma_rd,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} own_t;

    state_t            state_q, state_d;
    own_t              owner_q, owner_d;
    own_t              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0] dma_rd_q, dma_rd_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              grant_dma;

    always_comb begin
        grant_dma = 1'b0;
`ifdef DMEM_ARB_RR_EN
        // On a tie the DMA wins only when the CPU had the previous grant.
        grant_dma = dma_req && (!cpu_req || (last_grant_q == OWN_CPU));
`else
        grant_dma = dma_req && !cpu_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wd_d         = wd_q;
        cpu_rd_d     = cpu_rd_q;
        dma_rd_d     = dma_rd_q;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d      = grant_dma ? OWN_DMA : OWN_CPU;
                    last_grant_d = grant_dma ? OWN_DMA : OWN_CPU;
                    we_d         = grant_dma ? dma_we   : cpu_we;
                    addr_d       = grant_dma ? dma_addr : cpu_addr;
                    wd_d         = grant_dma ? dma_wd   : cpu_wd;
                    state_d      = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // Ack and read data are registered together so rd is valid with ack.
                state_d = IDLE;
                if (owner_q == OWN_CPU) begin
                    cpu_ack_d = 1'b1;
                    if (!we_q) cpu_rd_d = mem_rd;
                end else begin
                    dma_ack_d = 1'b1;
                    if (!we_q) dma_rd_d = mem_rd;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DMA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            cpu_rd_q     <= '0;
            dma_rd_q     <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            cpu_rd_q     <= cpu_rd_d;
            dma_rd_q     <= dma_rd_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wd    = wd_q;
    assign cpu_rd    = cpu_rd_q;
    assign dma_rd    = dma_rd_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_stall = cpu_req && !cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-read memory model behind the mem port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic        cpu_ack, cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wd, dma_rd;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [0:255];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          rr_mode;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_rd(dma_rd), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always @(posedge clk) begin
        if (rst) begin
            mem[8'h20] <= 32'h12345678;
            mem_rd     <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wd;
            else        mem_rd <= mem[mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef DMEM_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wd = 32'h0;
        tick();
        tick();
        chk("rst_cpu_rd",   cpu_rd,   32'h0);
        chk("rst_dma_rd",   dma_rd,   32'h0);
        chk("rst_cpu_ack",  {31'h0, cpu_ack}, 32'h0);
        chk("rst_dma_ack",  {31'h0, dma_ack}, 32'h0);
        chk("rst_mem_en",   {31'h0, mem_en},  32'h0);
        chk("rst_mem_we",   {31'h0, mem_we},  32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd",   mem_wd,   32'h0);
        rst = 1'b0;
        tick();

        // CPU write 0xDEADBEEF to 0x10
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'hDEADBEEF;
        #1;
        chk("w_stall_pre", {31'h0, cpu_stall}, 32'h1);
        chk("w_en_pre",    {31'h0, mem_en},    32'h0);
        tick();
        chk("w_acc_en",   {31'h0, mem_en},  32'h1);
        chk("w_acc_we",   {31'h0, mem_we},  32'h1);
        chk("w_acc_addr", mem_addr, 32'h10);
        chk("w_acc_wd",   mem_wd,   32'hDEADBEEF);
        chk("w_acc_ack",  {31'h0, cpu_ack}, 32'h0);
        chk("w_acc_stall",{31'h0, cpu_stall}, 32'h1);
        cpu_addr = 32'h99; cpu_wd = 32'h0;
        #1;
        chk("w_latched_addr", mem_addr, 32'h10);
        chk("w_latched_wd",   mem_wd,   32'hDEADBEEF);
        tick();
        chk("w_resp_en",   {31'h0, mem_en},  32'h0);
        chk("w_resp_we",   {31'h0, mem_we},  32'h0);
        chk("w_resp_addr", mem_addr, 32'h10);
        chk("w_resp_ack",  {31'h0, cpu_ack}, 32'h0);
        tick();
        chk("w_ack",       {31'h0, cpu_ack},   32'h1);
        chk("w_ack_stall", {31'h0, cpu_stall}, 32'h0);
        chk("w_ack_dma",   {31'h0, dma_ack},   32'h0);
        chk("w_ack_rd",    cpu_rd, 32'h0);
        cpu_req = 1'b0;
        tick();
        chk("w_ack_pulse", {31'h0, cpu_ack}, 32'h0);
        chk("w_idle_en",   {31'h0, mem_en},  32'h0);
        chk("w_mem_10",    mem[8'h10], 32'hDEADBEEF);

        // DMA read of preloaded 0x20
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        tick();
        chk("dr_en",   {31'h0, mem_en}, 32'h1);
        chk("dr_we",   {31'h0, mem_we}, 32'h0);
        chk("dr_addr", mem_addr, 32'h20);
        tick();
        tick();
        chk("dr_ack",     {31'h0, dma_ack}, 32'h1);
        chk("dr_cpu_ack", {31'h0, cpu_ack}, 32'h0);
        chk("dr_rd",      dma_rd, 32'h12345678);
        chk("dr_cpu_rd",  cpu_rd, 32'h0);
        dma_req = 1'b0;
        tick();
        chk("dr_ack_pulse", {31'h0, dma_ack}, 32'h0);
        chk("dr_rd_hold",   dma_rd, 32'h12345678);

        // CPU read, CPU write back-to-back, then DMA read of the written word
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        tick(); tick(); tick();
        chk("cr_ack", {31'h0, cpu_ack}, 32'h1);
        chk("cr_rd",  cpu_rd, 32'h12345678);
        cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wd = 32'hA5A5A5A5;
        tick(); tick(); tick();
        chk("cw_ack",     {31'h0, cpu_ack}, 32'h1);
        chk("cw_rd_hold", cpu_rd, 32'h12345678);
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
        tick(); tick(); tick();
        chk("dr40_ack", {31'h0, dma_ack}, 32'h1);
        chk("dr40_rd",  dma_rd, 32'hA5A5A5A5);
        dma_req = 1'b0;
        tick();

        // Both requesters hold read requests continuously
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("tie_grant_noack", {30'h0, cpu_ack, dma_ack}, 32'h0);
            chk("tie_grant_en",    {31'h0, mem_en}, 32'h1);
            tick();
            tick();
            chk("tie_cpu_ack", {31'h0, cpu_ack},
                (rr_mode && (k % 2 == 1)) ? 32'h0 : 32'h1);
            chk("tie_dma_ack", {31'h0, dma_ack},
                (rr_mode && (k % 2 == 1)) ? 32'h1 : 32'h0);
        end
        chk("tie_cpu_rd", cpu_rd, 32'hDEADBEEF);
        chk("tie_dma_rd", dma_rd, rr_mode ? 32'h12345678 : 32'hA5A5A5A5);
        cpu_req = 1'b0; dma_req = 1'b0;
        tick(); tick(); tick();
        chk("drop_no_ack", {30'h0, cpu_ack, dma_ack}, 32'h0);

        // Reset during the ACCESS cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wd = 32'h11112222;
        tick();
        chk("ab_acc_we", {31'h0, mem_we}, 32'h1);
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        chk("ab_en",    {31'h0, mem_en},  32'h0);
        chk("ab_we",    {31'h0, mem_we},  32'h0);
        chk("ab_ack",   {30'h0, cpu_ack, dma_ack}, 32'h0);
        chk("ab_cpu_rd", cpu_rd, 32'h0);
        chk("ab_dma_rd", dma_rd, 32'h0);
        chk("ab_addr",  mem_addr, 32'h0);
        chk("ab_wd",    mem_wd,   32'h0);
        chk("ab_stall", {31'h0, cpu_stall}, 32'h0);
        rst = 1'b0;
        tick(); tick();
        chk("ab_post_ack", {30'h0, cpu_ack, dma_ack}, 32'h0);
        chk("ab_post_en",  {31'h0, mem_en}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, the width of all data ports.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req, input, 1; cpu_we, input, 1; cpu_addr, input, ADDR_W; cpu_wd, input, DATA_W: the core data-memory request.
REQ-006 SHALL have ports cpu_rd, output, DATA_W: read data; cpu_ack, output, 1: completion pulse; cpu_stall, output, 1: core hold.
REQ-007 SHALL have ports dma_req, input, 1; dma_we, input, 1; dma_addr, input, ADDR_W; dma_wd, input, DATA_W: the secondary requester's request.
REQ-008 SHALL have ports dma_rd, output, DATA_W and dma_ack, output, 1.
REQ-009 SHALL have ports mem_en, output, 1; mem_we, output, 1; mem_addr, output, ADDR_W; mem_wd, output, DATA_W; mem_rd, input, DATA_W. mem_rd is valid one cycle after an enabled read.

Function
REQ-010 SHALL implement three states: IDLE, ACCESS and RESP.
REQ-011 In IDLE, SHALL latch owner, we, addr and wd from the winning requester when any req is high, then move to ACCESS; with no request it SHALL stay in IDLE.
REQ-012 In ACCESS, SHALL drive mem_en=1, mem_we=owner we, and mem_addr/mem_wd from the latched values, then move to RESP.
REQ-013 In RESP, SHALL pulse the owner's ack for exactly one cycle, register mem_rd into the owner's rd when the access was a read, then return to IDLE.
REQ-014 Latency SHALL be fixed: a request sampled in IDLE at edge N produces ack high in the cycle after edge N+2.
REQ-015 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr and mem_wd SHALL hold the last latched values.
REQ-016 cpu_rd and dma_rd SHALL hold their values until the next read ack to the same owner; a write ack SHALL leave rd unchanged.
REQ-017 cpu_stall SHALL equal cpu_req AND NOT cpu_ack, combinationally.
REQ-018 Requesters SHALL hold req and all request fields stable until ack. The arbiter SHALL ignore field changes after latching. Any req still high in IDLE SHALL start a new access.
REQ-019 When both req are high in the same IDLE cycle, SHALL resolve by the policy in REQ-024/025. The loser SHALL remain pending, with no loss and no ack.
REQ-020 A req dropped before grant SHALL be ignored; no ack SHALL be issued.
REQ-021 SHALL never assert cpu_ack and dma_ack in the same cycle, and SHALL never acknowledge a non-owner.

Reset
REQ-022 A rst high at a rising edge SHALL force state=IDLE and last_grant=DMA. It SHALL zero cpu_rd, dma_rd, the latched addr/wd/we and owner, and all ack outputs. mem_en and mem_we SHALL be 0 in the following cycle.
REQ-023 Reset during ACCESS or RESP SHALL abort the access with no ack. An abort during ACCESS SHALL produce no further mem_we after the reset edge.

Configuration
REQ-024 With macro DMEM_ARB_RR_EN defined, SHALL arbitrate round-robin: on a tie, grant the requester not in last_grant, then update last_grant to the winner on every grant.
REQ-025 Without DMEM_ARB_RR_EN, SHALL use fixed priority: the CPU always wins ties. last_grant SHALL still be maintained but SHALL not affect arbitration.

Verification
REQ-026 After reset, cpu_req=1, cpu_we=1, addr=0x10, wd=0xDEADBEEF -> mem_en=mem_we=1 with addr 0x10 and wd 0xDEADBEEF for exactly one cycle; cpu_ack pulses 2 cycles after grant; cpu_stall is high until that pulse.
REQ-027 Preloaded mem[0x20]=0x12345678, dma_req read 0x20 -> dma_rd=0x12345678 with dma_ack pulse; cpu_rd stays 0.
REQ-028 Both requesting reads continuously, macro defined -> grants alternate CPU, DMA, CPU, DMA. Macro undefined -> CPU only; dma_ack never pulses while cpu_req is held.
REQ-029 rst=1 in the ACCESS cycle of a CPU write -> no cpu_ack, state IDLE, mem_we=0 in the next cycle, all outputs zero.
REQ-030 Write 0xA5A5A5A5 at 0x40 by CPU, then DMA read of 0x40 -> dma_rd=0xA5A5A5A5; cpu_rd is unchanged by the write ack.
